packet_thresholder_n: RTL and testbench
=======================================

Name: packet_thresholder_n

Overview:
- Parametrised per-channel amplitude thresholder for one transceiver RX lane.
- Detects the packet header word, latches the timestamp word that follows, then compares each payload sample against a runtime-writable per-channel threshold.
- Emits a per-sample trigger strobe with channel index, amplitude and timestamp, plus end-of-packet and abort status, to the global trigger coordinator.
- Replaces the fixed-depth, ROM-based thresholder. Thresholds live in an internal register file, so lookup has no read latency.

Parameters:
- DATA_W, 16, RX word width.
- SAMPLE_W, 12, amplitude field width; uses RX_data[SAMPLE_W-1:0].
- N_CHAN, 125, payload samples per packet; minimum 1.
- CHAN_W, $clog2(N_CHAN), channel index width.
- HEADER, 16'hDEAD, start-of-packet word.
- THRESH_INIT, {SAMPLE_W{1'b1}}, reset value of every threshold (all-ones means nothing triggers).

Ports:
- rx_std_clkout, in, 1, sole clock.
- rst_n, in, 1, reset, asynchronous, active-low.
- rx_syncstatus, in, 2, transceiver sync status.
- rx_datak, in, 2, control-word flags.
- RX_data, in, DATA_W, received word.
- cfg_we, in, 1, threshold write enable.
- cfg_addr, in, CHAN_W, threshold channel to write.
- cfg_data, in, SAMPLE_W, threshold value.
- trig_valid, out, 1, one-cycle pulse: the sample exceeded its threshold.
- trig_chan, out, CHAN_W, channel of the triggering sample.
- trig_amp, out, SAMPLE_W, amplitude of the triggering sample.
- time_stamp, out, DATA_W, timestamp of the current or last packet.
- pkt_done, out, 1, pulse: all N_CHAN samples were checked.
- pkt_any_trig, out, 1, qualifies pkt_done: at least one trigger occurred in the packet.
- pkt_abort, out, 1, pulse: sync was lost mid-packet.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - State is IDLE.
  - Every threshold is set to THRESH_INIT.
- Word accepted:
  - A word is accepted when rx_syncstatus==2'b11 and rx_datak==2'b00.
  - If sync holds but datak!=0, the word is ignored: no state change, no counting.
- States:
  - IDLE: an accepted word equal to HEADER moves to TSTAMP. Any other word stays in IDLE.
  - TSTAMP: the next accepted word is loaded into time_stamp. Channel counter clears to 0. Move to CHECK.
  - CHECK: each accepted word is the sample for the current counter value.
    - Compare: RX_data[SAMPLE_W-1:0] > thresh[counter], unsigned, strictly greater.
    - Counter increments after each sample.
    - After the sample at channel N_CHAN-1, return to IDLE.
    - HEADER appearing inside the payload is treated as an ordinary sample.
- Trigger latency:
  - A sample accepted in cycle N produces trig_valid, trig_chan, trig_amp in cycle N+1.
  - trig_chan and trig_amp hold their value until the next trigger.
- End of packet:
  - pkt_done pulses in the same cycle as the result for channel N_CHAN-1.
  - pkt_any_trig is valid with pkt_done and includes that last sample.
  - The sticky any-trigger flag clears in TSTAMP.
- time_stamp holds its value from one TSTAMP load until the next; it is not cleared in IDLE.
- Sync loss (rx_syncstatus!=2'b11) while in TSTAMP or CHECK:
  - Next cycle: pkt_abort=1, state returns to IDLE.
  - No pkt_done for that packet; no further triggers from it.
  - Sync loss in IDLE does nothing.
- Config writes:
  - Take effect on the next clock edge, in any state.
  - If a write hits the channel being compared in the same cycle, the compare uses the old value.
  - cfg_addr >= N_CHAN is ignored.
- A back-to-back HEADER immediately after the last sample is accepted normally; no dead cycle is required.

Optional Feature:
- Macro: THRESH_POLARITY_EN.
- Defined:
  - Adds input port cfg_polarity [N_CHAN-1:0], quasi-static.
  - Bit=1: that channel triggers when sample < threshold (negative-going pulses).
  - Bit=0: sample > threshold.
- Undefined: the port is absent and all channels use >.

Decomposition:
- Package pkt_thresh_pkg holds:
  - state enum (IDLE/TSTAMP/CHECK),
  - default HEADER,
  - sync-OK constant 2'b11,
  - data-word constant 2'b00.
- One sub-module: thresh_regfile. It holds N_CHAN×SAMPLE_W registers with an async read port and a sync write port (write-before-read not required), and applies the THRESH_INIT reset.

Test Plan:
- Reset, then thresholds: ch3=100, others all-ones. Send DEAD, 0x1234, 125 samples of 0x050 with ch3=0x065 → exactly one trig_valid, trig_chan=3, trig_amp=0x065, time_stamp=0x1234; pkt_done with pkt_any_trig=1.
- Boundary: ch0 threshold=100, sample=100 → no trigger; sample=101 → trigger one cycle later.
- Insert rx_datak=2'b01 words mid-payload → skipped; counter unaffected; pkt_done still occurs after exactly 125 data samples.
- Drop rx_syncstatus to 2'b01 at sample 40 → pkt_abort pulse, no pkt_done, returns to IDLE; the next packet processes normally.
- Write ch5=0 in the same cycle ch5's sample=0x001 arrives with old threshold all-ones → no trigger; next packet ch5=0x001 → trigger.
- THRESH_POLARITY_EN: ch7 polarity=1, threshold=50, sample=49 → trigger; sample=50 → none.

Source files
------------

// File: rtl/pkt_thresh_pkg.sv
// Shared types and constants for the packet thresholder.
package pkt_thresh_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TSTAMP = 2'd1,
        ST_CHECK  = 2'd2
    } state_t;

    localparam logic [15:0] HEADER_DEFAULT = 16'hDEAD;
    localparam logic [1:0]  SYNC_OK        = 2'b11;
    localparam logic [1:0]  DATAK_DATA     = 2'b00;

    // Channel index width; a single-channel build still needs one bit.
    function automatic int unsigned chan_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/thresh_regfile.sv
// Per-channel threshold register file: async read, sync write, THRESH_INIT on reset.
module thresh_regfile
    import pkt_thresh_pkg::*;
#(
    parameter int unsigned         N_CHAN      = 125,
    parameter int unsigned         SAMPLE_W    = 12,
    parameter int unsigned         CHAN_W      = chan_width(N_CHAN),
    parameter logic [SAMPLE_W-1:0] THRESH_INIT = {SAMPLE_W{1'b1}}
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [CHAN_W-1:0]   i_waddr,
    input  logic [SAMPLE_W-1:0] i_wdata,
    input  logic [CHAN_W-1:0]   i_raddr,
    output logic [SAMPLE_W-1:0] o_rdata_c
);

    logic [SAMPLE_W-1:0] r_mem [N_CHAN];

    // Addresses at or beyond N_CHAN match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_CHAN); i++) r_mem[i] <= THRESH_INIT;
        end else begin
            for (int i = 0; i < int'(N_CHAN); i++) begin
                if (i_we && (i_waddr == CHAN_W'(i))) r_mem[i] <= i_wdata;
            end
        end
    end

    always_comb begin
        o_rdata_c = THRESH_INIT;
        for (int i = 0; i < int'(N_CHAN); i++) begin
            if (i_raddr == CHAN_W'(i)) o_rdata_c = r_mem[i];
        end
    end

endmodule

// File: rtl/packet_thresholder_n.sv
// Per-channel amplitude thresholder for one RX lane: header, timestamp, N_CHAN samples.
// Optional macro THRESH_POLARITY_EN adds per-channel "less-than" trigger polarity.
module packet_thresholder_n
    import pkt_thresh_pkg::*;
#(
    parameter int unsigned         DATA_W      = 16,
    parameter int unsigned         SAMPLE_W    = 12,
    parameter int unsigned         N_CHAN      = 125,
    parameter int unsigned         CHAN_W      = chan_width(N_CHAN),
    parameter logic [DATA_W-1:0]   HEADER      = DATA_W'(HEADER_DEFAULT),
    parameter logic [SAMPLE_W-1:0] THRESH_INIT = {SAMPLE_W{1'b1}}
) (
    input  logic                rx_std_clkout,
    input  logic                rst_n,
    input  logic [1:0]          rx_syncstatus,
    input  logic [1:0]          rx_datak,
    input  logic [DATA_W-1:0]   RX_data,
    input  logic                cfg_we,
    input  logic [CHAN_W-1:0]   cfg_addr,
    input  logic [SAMPLE_W-1:0] cfg_data,
`ifdef THRESH_POLARITY_EN
    input  logic [N_CHAN-1:0]   cfg_polarity,
`endif
    output logic                trig_valid,
    output logic [CHAN_W-1:0]   trig_chan,
    output logic [SAMPLE_W-1:0] trig_amp,
    output logic [DATA_W-1:0]   time_stamp,
    output logic                pkt_done,
    output logic                pkt_any_trig,
    output logic                pkt_abort
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CHAN_W-1:0]   r_cnt;
    logic                r_any;
    logic [SAMPLE_W-1:0] w_sample;
    logic [SAMPLE_W-1:0] w_thresh;
    logic                w_sync_ok;
    logic                w_accept;
    logic                w_cmp;
    logic                w_sample_en;
    logic                w_hit;
    logic                w_last;
    logic                w_abort;
    logic                w_load_ts;

    assign w_sync_ok = (rx_syncstatus == SYNC_OK);
    assign w_accept  = w_sync_ok && (rx_datak == DATAK_DATA);
    assign w_sample  = RX_data[SAMPLE_W-1:0];

    thresh_regfile #(
        .N_CHAN      (N_CHAN),
        .SAMPLE_W    (SAMPLE_W),
        .CHAN_W      (CHAN_W),
        .THRESH_INIT (THRESH_INIT)
    ) u_regfile (
        .clk       (rx_std_clkout),
        .rst_n     (rst_n),
        .i_we      (cfg_we),
        .i_waddr   (cfg_addr),
        .i_wdata   (cfg_data),
        .i_raddr   (r_cnt),
        .o_rdata_c (w_thresh)
    );

`ifdef THRESH_POLARITY_EN
    assign w_cmp = cfg_polarity[r_cnt] ? (w_sample < w_thresh) : (w_sample > w_thresh);
`else
    assign w_cmp = (w_sample > w_thresh);
`endif

    assign w_hit = w_sample_en && w_cmp;

    // Next-state and per-cycle control strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_sample_en = 1'b0;
        w_last      = 1'b0;
        w_abort     = 1'b0;
        w_load_ts   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (RX_data == HEADER)) w_state_nxt = ST_TSTAMP;
            end
            ST_TSTAMP: begin
                if (!w_sync_ok) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_load_ts   = 1'b1;
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!w_sync_ok) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_accept) begin
                    w_sample_en = 1'b1;
                    if (r_cnt == CHAN_W'(N_CHAN - 1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Channel counter and sticky any-trigger flag, both restarted by the timestamp word.
    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_any <= 1'b0;
        end else if (w_load_ts) begin
            r_cnt <= '0;
            r_any <= 1'b0;
        end else if (w_sample_en) begin
            r_cnt <= w_last ? '0 : r_cnt + CHAN_W'(1);
            r_any <= r_any | w_hit;
        end
    end

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            trig_valid   <= 1'b0;
            trig_chan    <= '0;
            trig_amp     <= '0;
            time_stamp   <= '0;
            pkt_done     <= 1'b0;
            pkt_any_trig <= 1'b0;
            pkt_abort    <= 1'b0;
        end else begin
            trig_valid   <= w_hit;
            pkt_done     <= w_last;
            pkt_any_trig <= w_last && (r_any || w_hit);
            pkt_abort    <= w_abort;
            if (w_hit) begin
                trig_chan <= r_cnt;
                trig_amp  <= w_sample;
            end
            if (w_load_ts) time_stamp <= RX_data;
        end
    end

endmodule

// File: tb/tb_packet_thresholder_n.sv
// Self-checking bench for packet_thresholder_n: per-cycle scoreboard plus directed checks.
module tb_packet_thresholder_n;

    localparam int unsigned NC = 125;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  sync;
    logic [1:0]  datak;
    logic [15:0] rx;
    logic        we;
    logic [6:0]  waddr;
    logic [11:0] wdata;
`ifdef THRESH_POLARITY_EN
    logic [NC-1:0] pol;
`endif
    logic        trig_valid;
    logic [6:0]  trig_chan;
    logic [11:0] trig_amp;
    logic [15:0] time_stamp;
    logic        pkt_done;
    logic        pkt_any_trig;
    logic        pkt_abort;

    always #5 clk = ~clk;

    packet_thresholder_n dut (
        .rx_std_clkout (clk),
        .rst_n         (rst_n),
        .rx_syncstatus (sync),
        .rx_datak      (datak),
        .RX_data       (rx),
        .cfg_we        (we),
        .cfg_addr      (waddr),
        .cfg_data      (wdata),
`ifdef THRESH_POLARITY_EN
        .cfg_polarity  (pol),
`endif
        .trig_valid    (trig_valid),
        .trig_chan     (trig_chan),
        .trig_amp      (trig_amp),
        .time_stamp    (time_stamp),
        .pkt_done      (pkt_done),
        .pkt_any_trig  (pkt_any_trig),
        .pkt_abort     (pkt_abort)
    );

    typedef struct packed {
        logic        tv;
        logic [6:0]  tc;
        logic [11:0] ta;
        logic [15:0] ts;
        logic        done;
        logic        any;
        logic        abort;
    } exp_t;

    typedef struct {
        logic [11:0] th;
        logic [11:0] smp;
        int          exp_trig;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        m_hold;
    int          m_state;
    int          m_cnt;
    logic        m_any;
    logic [11:0] m_thr[NC];
    logic [11:0] pkt[NC];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int obs_trig, obs_done, obs_abort;
    int obs_chan, obs_amp, obs_any;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_obs();
        obs_trig = 0; obs_done = 0; obs_abort = 0;
        obs_chan = -1; obs_amp = -1; obs_any = -1;
    endtask

    // Pops the expected record for this cycle and compares every output.
    task automatic check_cycle();
        exp_t g, got;
        cyc++;
        got = {trig_valid, trig_chan, trig_amp, time_stamp, pkt_done, pkt_any_trig, pkt_abort};
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty cycle %0d", cyc);
        end else begin
            g = sb_q.pop_front();
            if (got !== g) begin
                n_fail++;
                $display("FAIL cycle %0d: got tv=%0b ch=%0d amp=%h ts=%h done=%0b any=%0b abort=%0b, expected tv=%0b ch=%0d amp=%h ts=%h done=%0b any=%0b abort=%0b",
                         cyc, got.tv, got.tc, got.ta, got.ts, got.done, got.any, got.abort,
                         g.tv, g.tc, g.ta, g.ts, g.done, g.any, g.abort);
            end
        end
        if (trig_valid) begin obs_trig++; obs_chan = int'(trig_chan); obs_amp = int'(trig_amp); end
        if (pkt_done)   begin obs_done++; obs_any = int'(pkt_any_trig); end
        if (pkt_abort)  obs_abort++;
    endtask

    // Drives one cycle of inputs, predicts the outputs after the edge, then checks them.
    task automatic step(input logic [1:0] s, input logic [1:0] k, input logic [15:0] d,
                        input logic w, input logic [6:0] a, input logic [11:0] v);
        exp_t        e;
        logic        sok, acc, cmp, neg;
        logic [11:0] smp, th;
        @(negedge clk);
        sync = s; datak = k; rx = d; we = w; waddr = a; wdata = v;
        e = m_hold;
        e.tv = 1'b0; e.done = 1'b0; e.any = 1'b0; e.abort = 1'b0;
        sok = (s == 2'b11);
        acc = sok && (k == 2'b00);
        smp = d[11:0];
        case (m_state)
            0: if (acc && d == 16'hDEAD) m_state = 1;
            1: begin
                if (!sok) begin e.abort = 1'b1; m_state = 0; end
                else if (acc) begin e.ts = d; m_cnt = 0; m_any = 1'b0; m_state = 2; end
            end
            default: begin
                if (!sok) begin e.abort = 1'b1; m_state = 0; end
                else if (acc) begin
                    th  = m_thr[m_cnt];
                    neg = 1'b0;
`ifdef THRESH_POLARITY_EN
                    neg = pol[m_cnt];
`endif
                    cmp = neg ? (smp < th) : (smp > th);
                    if (cmp) begin e.tv = 1'b1; e.tc = 7'(m_cnt); e.ta = smp; m_any = 1'b1; end
                    if (m_cnt == NC - 1) begin e.done = 1'b1; e.any = m_any; m_state = 0; end
                    else m_cnt++;
                end
            end
        endcase
        if (w && int'(a) < NC) m_thr[a] = v;
        m_hold = e;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        check_cycle();
    endtask

    task automatic word(input logic [15:0] d);
        step(2'b11, 2'b00, d, 1'b0, 7'd0, 12'd0);
    endtask

    // Threshold write while the link is out of sync, so no word is accepted.
    task automatic wr_thr(input int a, input int v);
        step(2'b00, 2'b00, 16'h0000, 1'b1, 7'(a), 12'(v));
    endtask

    task automatic fill(input logic [11:0] v);
        for (int i = 0; i < int'(NC); i++) pkt[i] = v;
    endtask

    task automatic send_packet(input logic [15:0] ts);
        word(16'hDEAD);
        word(ts);
        for (int i = 0; i < int'(NC); i++) word({4'h0, pkt[i]});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        vt[0] = '{th: 12'd100,  smp: 12'd100,  exp_trig: 0};
        vt[1] = '{th: 12'd100,  smp: 12'd101,  exp_trig: 1};
        vt[2] = '{th: 12'd100,  smp: 12'd99,   exp_trig: 0};
        vt[3] = '{th: 12'd0,    smp: 12'd0,    exp_trig: 0};
        vt[4] = '{th: 12'd0,    smp: 12'd1,    exp_trig: 1};
        vt[5] = '{th: 12'hFFF,  smp: 12'hFFF,  exp_trig: 0};
        vt[6] = '{th: 12'hFFE,  smp: 12'hFFF,  exp_trig: 1};
        vt[7] = '{th: 12'h800,  smp: 12'h7FF,  exp_trig: 0};

        rst_n = 1'b0; sync = 2'b00; datak = 2'b00; rx = '0; we = 1'b0; waddr = '0; wdata = '0;
`ifdef THRESH_POLARITY_EN
        pol = '0;
`endif
        m_hold = '0; m_state = 0; m_cnt = 0; m_any = 1'b0;
        for (int i = 0; i < int'(NC); i++) m_thr[i] = 12'hFFF;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({trig_valid, trig_chan, trig_amp, time_stamp, pkt_done, pkt_any_trig, pkt_abort}), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single trigger on ch3, followed back-to-back by a trigger-free packet.
        wr_thr(3, 100);
        fill(12'h050); pkt[3] = 12'h065;
        clear_obs();
        send_packet(16'h1234);
        chk("p1_trig_count", obs_trig, 1);
        chk("p1_trig_chan", obs_chan, 3);
        chk("p1_trig_amp", obs_amp, 12'h065);
        chk("p1_time_stamp", int'(time_stamp), 16'h1234);
        chk("p1_done", obs_done, 1);
        chk("p1_any", obs_any, 1);
        fill(12'h050);
        clear_obs();
        send_packet(16'h5678);
        chk("p2_trig_count", obs_trig, 0);
        chk("p2_done", obs_done, 1);
        chk("p2_any", obs_any, 0);
        word(16'h0001);
        word(16'h0002);
        chk("ts_hold_idle", int'(time_stamp), 16'h5678);
        chk("chan_hold", int'(trig_chan), 3);
        wr_thr(3, 12'hFFF);

        // Strict-greater boundary on channel 0.
        for (int i = 0; i < 8; i++) begin
            wr_thr(0, int'(vt[i].th));
            fill(12'h000); pkt[0] = vt[i].smp;
            clear_obs();
            send_packet(16'(16'h0100 + i));
            chk($sformatf("bound%0d_trig", i), obs_trig, vt[i].exp_trig);
            chk($sformatf("bound%0d_any", i), obs_any, vt[i].exp_trig);
        end
        wr_thr(0, 12'hFFF);

        // Control words scattered through the packet are skipped.
        wr_thr(10, 0);
        fill(12'h000); pkt[10] = 12'h005;
        clear_obs();
        word(16'hDEAD);
        step(2'b11, 2'b01, 16'hBEEF, 1'b0, 7'd0, 12'd0);
        word(16'h0ABC);
        for (int i = 0; i < int'(NC); i++) begin
            if (i % 20 == 7) step(2'b11, 2'b01, 16'hDEAD, 1'b0, 7'd0, 12'd0);
            if (i == 10)     step(2'b11, 2'b10, 16'h0FFF, 1'b0, 7'd0, 12'd0);
            word({4'h0, pkt[i]});
        end
        chk("datak_done", obs_done, 1);
        chk("datak_trig", obs_trig, 1);
        chk("datak_chan", obs_chan, 10);
        chk("datak_ts", int'(time_stamp), 16'h0ABC);
        wr_thr(10, 12'hFFF);

        // Sync loss at sample 40, then a clean packet.
        wr_thr(20, 0);
        wr_thr(50, 0);
        fill(12'h000); pkt[20] = 12'h003; pkt[50] = 12'h003;
        clear_obs();
        word(16'hDEAD);
        word(16'h4444);
        for (int i = 0; i < 40; i++) word({4'h0, pkt[i]});
        step(2'b01, 2'b00, 16'h0003, 1'b0, 7'd0, 12'd0);
        for (int i = 0; i < 5; i++) word(16'h0003);
        chk("abort_count", obs_abort, 1);
        chk("abort_no_done", obs_done, 0);
        chk("abort_trig", obs_trig, 1);
        clear_obs();
        send_packet(16'h4545);
        chk("post_abort_done", obs_done, 1);
        chk("post_abort_trig", obs_trig, 2);
        chk("post_abort_no_abort", obs_abort, 0);
        clear_obs();
        word(16'hDEAD);
        step(2'b10, 2'b00, 16'h1111, 1'b0, 7'd0, 12'd0);
        chk("tstamp_abort", obs_abort, 1);
        wr_thr(20, 12'hFFF);
        wr_thr(50, 12'hFFF);

        // Write to the channel under compare uses the old threshold; out-of-range write dropped.
        fill(12'h000); pkt[5] = 12'h001;
        clear_obs();
        word(16'hDEAD);
        word(16'h5555);
        for (int i = 0; i < int'(NC); i++) begin
            if (i == 5) step(2'b11, 2'b00, 16'h0001, 1'b1, 7'd5, 12'd0);
            else        step(2'b11, 2'b00, {4'h0, pkt[i]}, 1'b1, 7'd127, 12'd0);
        end
        chk("samecyc_trig", obs_trig, 0);
        clear_obs();
        send_packet(16'h5656);
        chk("newthr_trig", obs_trig, 1);
        chk("newthr_chan", obs_chan, 5);
        wr_thr(5, 12'hFFF);

`ifdef THRESH_POLARITY_EN
        // Negative-going polarity on ch7.
        wr_thr(7, 50);
        pol[7] = 1'b1;
        fill(12'h000); pkt[7] = 12'd49;
        clear_obs();
        send_packet(16'h7777);
        chk("pol_below_trig", obs_trig, 1);
        chk("pol_below_chan", obs_chan, 7);
        pkt[7] = 12'd50;
        clear_obs();
        send_packet(16'h7878);
        chk("pol_equal_trig", obs_trig, 0);
`endif

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
